// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//
// Seconds countdown timer with start/pause control and a timed alarm phase.
// A prescaler divides clk down to one-second ticks; each tick in RUN takes one
// second off the remaining count. Reaching zero enters ALARM for ALARM_SEC
// ticks, after which the block returns to IDLE and reloads the preset.
//
// Parameters:
//   TICK_DIV   clk cycles per one-second tick (2 .. 2^24)
//   ALARM_SEC  ticks spent in ALARM before returning to IDLE (1 .. 15)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start_stop  in   debounced level; each rising edge is a start/pause command
//   clear       in   synchronous level; forces IDLE while high
//   preset[9:0] in   countdown start value in seconds (clamped to 999)
//   remaining   out  seconds remaining
//   running     out  high in RUN (registered state decode)
//   tick        out  one-cycle pulse on each one-second boundary
//   alarm       out  high in ALARM (registered state decode)
// -----------------------------------------------------------------------------
module countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic [9:0] preset,
    output logic [9:0] remaining,
    output logic       running,
    output logic       tick,
    output logic       alarm
);

    localparam logic [23:0] PRESC_MAX  = 24'(TICK_DIV - 1);
    localparam logic [4:0]  ALARM_LAST = 5'(ALARM_SEC);
    localparam logic [9:0]  PRESET_MAX = 10'd999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_t;

    state_t      state_q,     state_d;
    logic [23:0] presc_q,     presc_d;
    logic [3:0]  alarm_cnt_q, alarm_cnt_d;
    logic [9:0]  remaining_q, remaining_d;
    logic        start_stop_q;

    logic        start_cmd;
    logic [9:0]  preset_clamped;
    logic        counting;
    logic [4:0]  alarm_cnt_inc;

    // Rising edge of the start/stop level against last cycle's sample.
    assign start_cmd      = start_stop & ~start_stop_q;
    assign preset_clamped = (preset > PRESET_MAX) ? PRESET_MAX : preset;
    assign counting       = (state_q == ST_RUN) || (state_q == ST_ALARM);
    assign tick           = counting && (presc_q == PRESC_MAX);
    // One bit wider so the compare against ALARM_SEC cannot wrap.
    assign alarm_cnt_inc  = {1'b0, alarm_cnt_q} + 5'd1;

    assign remaining = remaining_q;
    assign running   = (state_q == ST_RUN);
    assign alarm     = (state_q == ST_ALARM);

    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            alarm_cnt_q  <= '0;
            remaining_q  <= '0;
            start_stop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            alarm_cnt_q  <= alarm_cnt_d;
            remaining_q  <= remaining_d;
            start_stop_q <= start_stop;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        remaining_d = remaining_q;

        if (clear) begin
            // Clear outranks both start_cmd and tick.
            state_d     = ST_IDLE;
            presc_d     = '0;
            alarm_cnt_d = '0;
            remaining_d = preset_clamped;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d     = '0;
                    alarm_cnt_d = '0;
                    remaining_d = preset_clamped;
                    if (start_cmd && (preset_clamped != 10'd0)) begin
                        state_d = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        // <= 1 rather than == 1 keeps remaining from ever wrapping.
                        if (remaining_q <= 10'd1) begin
                            remaining_d = '0;
                            alarm_cnt_d = '0;
                            state_d     = ST_ALARM;
                        end else begin
                            remaining_d = remaining_q - 10'd1;
                            if (start_cmd) begin
                                state_d = ST_PAUSE;
                            end
                        end
                    end else if (start_cmd) begin
                        // Pausing freezes the prescaler at its current phase.
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + 24'd1;
                    end
                end

                ST_PAUSE: begin
                    if (start_cmd) begin
                        state_d = ST_RUN;
                    end
                end

                ST_ALARM: begin
                    remaining_d = '0;
                    presc_d     = tick ? 24'd0 : presc_q + 24'd1;
                    if (start_cmd || (tick && (alarm_cnt_inc == ALARM_LAST))) begin
                        state_d     = ST_IDLE;
                        presc_d     = '0;
                        alarm_cnt_d = '0;
                        remaining_d = preset_clamped;
                    end else if (tick) begin
                        alarm_cnt_d = alarm_cnt_inc[3:0];
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//
// Self-checking bench for countdown_ctrl with TICK_DIV = 4, ALARM_SEC = 2.
// A hand-derived vector table covers a full countdown and the preset corners,
// hand-written sequences cover pause/resume, start+clear and mid-run reset,
// and a random phase compares the DUT against a cycle-count based model.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

    localparam int TD = 4;
    localparam int AS = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic [9:0] preset;
    logic [9:0] remaining;
    logic       running;
    logic       tick;
    logic       alarm;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: seconds left, counted cycles since the last start from
    // IDLE (a tick falls on every TD-th counted cycle), and alarm ticks seen.
    int m_mode;
    int m_rem;
    int m_cycles;
    int m_aticks;
    bit m_prev_ss;

    typedef struct {
        logic       ss;
        logic       clr;
        logic [9:0] pre;
        int         rem;
        logic       run;
        logic       tck;
        logic       alm;
    } vec_t;

    vec_t tbl[$];

    countdown_ctrl #(
        .TICK_DIV  (TD),
        .ALARM_SEC (AS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .preset     (preset),
        .remaining  (remaining),
        .running    (running),
        .tick       (tick),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int p);
        return (p > 999) ? 999 : p;
    endfunction

    function automatic bit m_tick();
        return ((m_mode == M_RUN) || (m_mode == M_ALARM)) && ((m_cycles % TD) == TD - 1);
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_rem     = 0;
        m_cycles  = 0;
        m_aticks  = 0;
        m_prev_ss = 1'b0;
    endtask

    task automatic model_to_idle(input int pc);
        m_mode   = M_IDLE;
        m_rem    = pc;
        m_cycles = 0;
        m_aticks = 0;
    endtask

    task automatic model_step(input bit ss, input bit clr, input int pre);
        bit cmd;
        bit t;
        int pc;
        cmd = ss && !m_prev_ss;
        t   = m_tick();
        pc  = clamp(pre);
        if (clr) begin
            model_to_idle(pc);
        end else begin
            case (m_mode)
                M_IDLE: begin
                    model_to_idle(pc);
                    if (cmd && pc != 0) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (t) begin
                        m_cycles++;
                        m_rem--;
                        if (m_rem == 0) begin
                            m_mode   = M_ALARM;
                            m_aticks = 0;
                        end else if (cmd) begin
                            m_mode = M_PAUSE;
                        end
                    end else if (cmd) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_cycles++;
                    end
                end
                M_PAUSE: begin
                    if (cmd) m_mode = M_RUN;
                end
                default: begin
                    m_rem = 0;
                    m_cycles++;
                    if (cmd) begin
                        model_to_idle(pc);
                    end else if (t) begin
                        m_aticks++;
                        if (m_aticks == AS) model_to_idle(pc);
                    end
                end
            endcase
        end
        m_prev_ss = ss;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".remaining"}, int'(remaining), m_rem);
        check({tag, ".running"},   int'(running),   int'(m_mode == M_RUN));
        check({tag, ".tick"},      int'(tick),      int'(m_tick()));
        check({tag, ".alarm"},     int'(alarm),     int'(m_mode == M_ALARM));
    endtask

    // Called just after a falling edge: drive, clock once, compare at the next falling edge.
    task automatic step(input logic ss, input logic clr, input logic [9:0] pre, input string tag);
        start_stop = ss;
        clear      = clr;
        preset     = pre;
        model_step(ss, clr, int'(pre));
        @(posedge clk);
        @(negedge clk);
        compare_model(tag);
    endtask

    function automatic vec_t mk(input logic ss, input logic clr, input logic [9:0] pre,
                                input int rem, input logic run, input logic tck, input logic alm);
        vec_t v;
        v.ss = ss; v.clr = clr; v.pre = pre;
        v.rem = rem; v.run = run; v.tck = tck; v.alm = alm;
        return v;
    endfunction

    initial begin
        // Full countdown from 3: tick every 4 cycles, 8 alarm cycles, back to IDLE.
        tbl.push_back(mk(0, 0, 10'd3,    3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 10'd3,    3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 10'd3,    2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 10'd3,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 10'd3,    1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 10'd3,    0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 10'd3,    3, 0, 0, 0));
        // Zero preset ignores the start command; oversize preset clamps.
        tbl.push_back(mk(1, 0, 10'd0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 10'd0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 10'd1023, 999, 0, 0, 0));

        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        preset     = 10'd3;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.remaining", int'(remaining), 0);
        check("reset.running",   int'(running),   0);
        check("reset.tick",      int'(tick),      0);
        check("reset.alarm",     int'(alarm),     0);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("tbl[%0d]", i);
            step(tbl[i].ss, tbl[i].clr, tbl[i].pre, tag);
            check({tag, ".exp_remaining"}, int'(remaining), tbl[i].rem);
            check({tag, ".exp_running"},   int'(running),   int'(tbl[i].run));
            check({tag, ".exp_tick"},      int'(tick),      int'(tbl[i].tck));
            check({tag, ".exp_alarm"},     int'(alarm),     int'(tbl[i].alm));
        end

        // Clamped preset: first decrement from 999 gives 998.
        step(1, 0, 10'd1023, "clamp.start");
        for (int i = 0; i < TD; i++) step(0, 0, 10'd1023, "clamp.run");
        check("clamp.first_dec", int'(remaining), 998);
        step(0, 1, 10'd1023, "clamp.clear");

        // ---------------- pause / resume ----------------
        step(0, 0, 10'd5, "pause.idle");
        step(1, 0, 10'd5, "pause.start");
        for (int i = 0; i < 5; i++) step(0, 0, 10'd5, "pause.run");
        check("pause.rem_before", int'(remaining), 4);
        step(1, 0, 10'd5, "pause.cmd");
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 10'd5, "pause.hold");
            check("pause.held_rem",  int'(remaining), 4);
            check("pause.held_tick", int'(tick),      0);
        end
        step(1, 0, 10'd5, "resume.cmd");
        check("resume.running",  int'(running), 1);
        check("resume.tick_c0",  int'(tick),    0);
        step(0, 0, 10'd5, "resume.c1");
        check("resume.tick_c1",  int'(tick),    0);
        step(0, 0, 10'd5, "resume.c2");
        check("resume.tick_c2",  int'(tick),    1);
        step(0, 0, 10'd5, "resume.dec");
        check("resume.rem_after", int'(remaining), 3);
        step(0, 1, 10'd5, "resume.clear");

        // ---------------- start and clear together ----------------
        step(0, 0, 10'd7, "sc.idle");
        step(1, 0, 10'd7, "sc.start");
        step(0, 0, 10'd7, "sc.run");
        step(1, 1, 10'd7, "sc.both");
        check("sc.running",   int'(running),   0);
        check("sc.remaining", int'(remaining), 7);
        step(0, 0, 10'd7, "sc.after");
        check("sc.still_idle", int'(running), 0);

        // ---------------- asynchronous reset mid-run ----------------
        step(1, 0, 10'd3, "ar.start");
        for (int i = 0; i < TD + 1; i++) step(0, 0, 10'd3, "ar.run");
        check("ar.rem_before", int'(remaining), 2);
        #2 rst = 1'b1;
        #1;
        check("ar.remaining_now", int'(remaining), 0);
        check("ar.running_now",   int'(running),   0);
        check("ar.tick_now",      int'(tick),      0);
        check("ar.alarm_now",     int'(alarm),     0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 10'd3, "ar.release");
        check("ar.reload", int'(remaining), 3);

        // ---------------- random phase against the model ----------------
        begin
            logic [9:0] pre;
            logic       ss;
            logic       clr;
            pre = 10'd3;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 19))
                        0:       pre = 10'd0;
                        1:       pre = 10'($urandom_range(1000, 1023));
                        2:       pre = 10'($urandom_range(7, 999));
                        default: pre = 10'($urandom_range(1, 6));
                    endcase
                end
                ss  = ($urandom_range(0, 7) == 0);
                clr = ($urandom_range(0, 63) == 0);
                step(ss, clr, pre, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
